// File: rtl/vga_register_panel_ctrl_pkg.sv
// Shared constants and types for the register panel: band count, highlight states, colours, off-screen line.
package vga_register_panel_ctrl_pkg;

    localparam int          NUM_BANDS     = 4;
    localparam logic [2:0]  COLOUR_ON_DEF = 3'b100;
    localparam logic [2:0]  COLOUR_HL_DEF = 3'b110;
    localparam logic [10:0] V_OFFSCREEN   = 11'h7FF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } hl_state_t;

    typedef struct packed {
        logic        band_valid;
        logic [1:0]  band_idx;
        logic [7:0]  rend_data;
        logic [10:0] rend_h;
        logic [10:0] rend_v;
        logic [2:0]  rend_colour_on;
    } rend_t;

    // First line of band k; wraps at 11 bits like the hardware comparators.
    function automatic logic [10:0] band_base(input logic [10:0] base,
                                              input logic [10:0] pitch,
                                              input logic [2:0]  k);
        return base + 11'(k) * pitch;
    endfunction

endpackage

// File: rtl/panel_snapshot.sv
// Shadow bank of the four live registers, loaded together when cap_en is high; 1 cycle load latency.
// No backpressure: a capture is always accepted.
module panel_snapshot
    import vga_register_panel_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cap_en,
    input  logic [7:0]                  reg_a,
    input  logic [7:0]                  reg_b,
    input  logic [7:0]                  reg_bus,
    input  logic [7:0]                  reg_out,
    output logic [NUM_BANDS-1:0][7:0]   shadow
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (cap_en) begin
            shadow <= {reg_out, reg_bus, reg_b, reg_a};
        end
    end

endmodule

// File: rtl/vga_register_panel_ctrl.sv
// Maps four register snapshots onto stacked screen bands for one shared renderer; outputs 1 cycle after vga_h/vga_v.
// No backpressure: pixel stream is free-running, one result per cycle.
module vga_register_panel_ctrl
    import vga_register_panel_ctrl_pkg::*;
#(
    parameter logic [10:0] PANEL_V    = 11'd10,
    parameter logic [10:0] BAND_PITCH = 11'd24,
    parameter logic [10:0] SNAP_LINE  = 11'd600,
    parameter logic [2:0]  COLOUR_ON  = COLOUR_ON_DEF,
    parameter logic [2:0]  COLOUR_HL  = COLOUR_HL_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  reg_a,
    input  logic [7:0]  reg_b,
    input  logic [7:0]  reg_bus,
    input  logic [7:0]  reg_out,
    input  logic [10:0] vga_h,
    input  logic [10:0] vga_v,
    input  logic        hold,
    input  logic        sel_step,
    output logic [7:0]  rend_data,
    output logic [10:0] rend_h,
    output logic [10:0] rend_v,
    output logic [2:0]  rend_colour_on,
    output logic        band_valid,
    output logic [1:0]  band_idx,
    output logic        frame_tick,
    output logic [7:0]  frame_cnt
);

    localparam rend_t REND_RESET = '{band_valid: 1'b0, band_idx: 2'd0, rend_data: 8'd0,
                                     rend_h: 11'd0, rend_v: V_OFFSCREEN, rend_colour_on: COLOUR_ON};

    logic                      fb;
    logic [NUM_BANDS-1:0][7:0] shadow;
    logic                      sync_1, sync_2, sync_d;
    logic                      step_pulse, step_pend, advance;
    hl_state_t                 state_q, state_d;
    logic [1:0]                hl_idx_q, hl_idx_d;
    logic                      hit;
    logic [1:0]                hit_idx;
    logic [10:0]               hit_off;
    rend_t                     rend_d, rend_q;

    assign fb = (vga_v == SNAP_LINE) && (vga_h == 11'd0);

    panel_snapshot u_snapshot (
        .clk     (clk),
        .reset_n (reset_n),
        .cap_en  (fb & ~hold),
        .reg_a   (reg_a),
        .reg_b   (reg_b),
        .reg_bus (reg_bus),
        .reg_out (reg_out),
        .shadow  (shadow)
    );

    // sel_step is a raw push-button: synchronise, then take the rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync_1 <= sel_step;
            sync_2 <= sync_1;
            sync_d <= sync_2;
        end
    end

    assign step_pulse = sync_2 & ~sync_d;
    assign advance    = step_pend | step_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_pend <= 1'b0;
        end else if (fb) begin
            step_pend <= 1'b0;
        end else if (step_pulse) begin
            step_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            hl_idx_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            hl_idx_q <= hl_idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hl_idx_d = hl_idx_q;
        if (fb && advance) begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SEL;
                    hl_idx_d = 2'd0;
                end
                ST_SEL: begin
                    if (hl_idx_q == 2'd3) begin
                        state_d  = ST_IDLE;
                        hl_idx_d = 2'd0;
                    end else begin
                        hl_idx_d = hl_idx_q + 2'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    hl_idx_d = 2'd0;
                end
            endcase
        end
    end

    // Walk bands from the top down so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        hit_off = 11'd0;
        for (int k = NUM_BANDS - 1; k >= 0; k--) begin
            if (vga_v >= band_base(PANEL_V, BAND_PITCH, 3'(k)) &&
                vga_v <  band_base(PANEL_V, BAND_PITCH, 3'(k + 1))) begin
                hit     = 1'b1;
                hit_idx = 2'(k);
                hit_off = band_base(11'd0, BAND_PITCH, 3'(k));
            end
        end
    end

    always_comb begin
        rend_d                = REND_RESET;
        rend_d.rend_h         = vga_h;
        rend_d.band_valid     = hit;
        rend_d.band_idx       = hit ? hit_idx : 2'd0;
        rend_d.rend_data      = hit ? shadow[hit_idx] : 8'd0;
        rend_d.rend_v         = hit ? (vga_v - hit_off) : V_OFFSCREEN;
        rend_d.rend_colour_on = (state_q == ST_SEL && hit && hit_idx == hl_idx_q) ? COLOUR_HL : COLOUR_ON;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rend_q     <= REND_RESET;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            rend_q     <= rend_d;
            frame_tick <= fb;
            if (fb) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign band_valid     = rend_q.band_valid;
    assign band_idx       = rend_q.band_idx;
    assign rend_data      = rend_q.rend_data;
    assign rend_h         = rend_q.rend_h;
    assign rend_v         = rend_q.rend_v;
    assign rend_colour_on = rend_q.rend_colour_on;

endmodule

// File: tb/tb_vga_register_panel_ctrl.sv
// Bench for vga_register_panel_ctrl: random register values and pixel positions against a frame-level model.
module tb_vga_register_panel_ctrl;

    localparam int         PANEL_V    = 10;
    localparam int         BAND_PITCH = 24;
    localparam int         SNAP_LINE  = 600;
    localparam logic [2:0] C_ON       = 3'b100;
    localparam logic [2:0] C_HL       = 3'b110;
    localparam logic [35:0] RESET_OBS = {1'b0, 2'd0, 8'h00, 11'd0, 11'h7FF, C_ON};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  reg_a, reg_b, reg_bus, reg_out;
    logic [10:0] vga_h, vga_v;
    logic        hold, sel_step;
    logic [7:0]  rend_data;
    logic [10:0] rend_h, rend_v;
    logic [2:0]  rend_colour_on;
    logic        band_valid;
    logic [1:0]  band_idx;
    logic        frame_tick;
    logic [7:0]  frame_cnt;
    logic [35:0] obs;

    int checks = 0;
    int errors = 0;

    // Model: shadow values, frame count, highlight position (-1 = none), pending step.
    logic [7:0] m_shadow [4];
    int         m_cnt;
    int         m_hl;
    int         m_pend;

    always #5 clk = ~clk;

    vga_register_panel_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .reg_a          (reg_a),
        .reg_b          (reg_b),
        .reg_bus        (reg_bus),
        .reg_out        (reg_out),
        .vga_h          (vga_h),
        .vga_v          (vga_v),
        .hold           (hold),
        .sel_step       (sel_step),
        .rend_data      (rend_data),
        .rend_h         (rend_h),
        .rend_v         (rend_v),
        .rend_colour_on (rend_colour_on),
        .band_valid     (band_valid),
        .band_idx       (band_idx),
        .frame_tick     (frame_tick),
        .frame_cnt      (frame_cnt)
    );

    assign obs = {band_valid, band_idx, rend_data, rend_h, rend_v, rend_colour_on};

    function automatic logic [35:0] exp_pixel(input int v, input int h);
        int k;
        if (v >= PANEL_V && (v - PANEL_V) / BAND_PITCH < 4) begin
            k = (v - PANEL_V) / BAND_PITCH;
            return {1'b1, 2'(k), m_shadow[k], 11'(h), 11'(v - k * BAND_PITCH),
                    (m_hl == k) ? C_HL : C_ON};
        end
        return {1'b0, 2'd0, 8'h00, 11'(h), 11'h7FF, C_ON};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
        m_cnt  = 0;
        m_hl   = -1;
        m_pend = 0;
    endtask

    task automatic model_fb();
        m_cnt = (m_cnt + 1) % 256;
        if (!hold) begin
            m_shadow[0] = reg_a;
            m_shadow[1] = reg_b;
            m_shadow[2] = reg_bus;
            m_shadow[3] = reg_out;
        end
        if (m_pend != 0) m_hl = (m_hl == 3) ? -1 : m_hl + 1;
        m_pend = 0;
    endtask

    task automatic randomise_regs();
        reg_a   = 8'($urandom);
        reg_b   = 8'($urandom);
        reg_bus = 8'($urandom);
        reg_out = 8'($urandom);
    endtask

    task automatic drive_px(input int v, input int h);
        vga_v = 11'(v);
        vga_h = 11'(h);
        @(negedge clk);
    endtask

    task automatic do_fb();
        drive_px(SNAP_LINE, 0);
        model_fb();
        vga_v = 11'd0;
        vga_h = 11'd1;
        @(negedge clk);
    endtask

    task automatic pulse_sel();
        sel_step = 1'b1;
        repeat (3) @(negedge clk);
        sel_step = 1'b0;
        repeat (3) @(negedge clk);
        m_pend = 1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        hold     = 1'b0;
        sel_step = 1'b0;
        randomise_regs();
        vga_v = 11'd30;
        vga_h = 11'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== RESET_OBS) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs, RESET_OBS);
        end
        checks++;
        if ({frame_tick, frame_cnt} !== 9'd0) begin
            errors++; $display("FAIL reset_frame got %b/%0d exp 0/0", frame_tick, frame_cnt);
        end
        reset_n = 1'b1;
        model_reset();
        drive_px(30, 5);
        checks++;
        if (obs !== exp_pixel(30, 5)) begin
            errors++; $display("FAIL post_reset_px got %h exp %h", obs, exp_pixel(30, 5));
        end
    endtask

    task automatic test_snapshot();
        int v, h;
        randomise_regs();
        reg_a = 8'hA5;
        do_fb();
        drive_px(10, 0);
        checks++;
        if (obs !== exp_pixel(10, 0) || rend_data !== 8'hA5) begin
            errors++; $display("FAIL snap_band0 got %h exp %h", obs, exp_pixel(10, 0));
        end
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 140);
            h = $urandom_range(0, 799);
            drive_px(v, h);
            checks++;
            if (obs !== exp_pixel(v, h)) begin
                errors++; $display("FAIL snap_rand v=%0d h=%0d got %h exp %h", v, h, obs, exp_pixel(v, h));
            end
        end
    endtask

    task automatic test_bands();
        int vs [7] = '{34, 58, 82, 106, 9, 33, 105};
        int h;
        foreach (vs[i]) begin
            h = $urandom_range(0, 799);
            drive_px(vs[i], h);
            checks++;
            if (obs !== exp_pixel(vs[i], h)) begin
                errors++; $display("FAIL band_edge v=%0d got %h exp %h", vs[i], obs, exp_pixel(vs[i], h));
            end
        end
    endtask

    task automatic test_hold();
        reg_b = 8'h01;
        hold  = 1'b0;
        do_fb();
        reg_b = 8'hFF;
        hold  = 1'b1;
        drive_px(SNAP_LINE, 0);
        model_fb();
        vga_v = 11'd0;
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL hold_tick got %b exp 1", frame_tick);
        end
        @(negedge clk);
        checks++;
        if (frame_cnt !== 8'(m_cnt)) begin
            errors++; $display("FAIL hold_cnt got %0d exp %0d", frame_cnt, m_cnt);
        end
        drive_px(34, 3);
        checks++;
        if (obs !== exp_pixel(34, 3) || rend_data !== 8'h01) begin
            errors++; $display("FAIL hold_freeze got %h exp %h", obs, exp_pixel(34, 3));
        end
        hold = 1'b0;
        do_fb();
        drive_px(40, 0);
        checks++;
        if (obs !== exp_pixel(40, 0)) begin
            errors++; $display("FAIL hold_release got %h exp %h", obs, exp_pixel(40, 0));
        end
    endtask

    task automatic test_select();
        int v0, v1;
        repeat (3) pulse_sel();
        do_fb();
        v0 = PANEL_V + 5;
        v1 = PANEL_V + BAND_PITCH + 5;
        drive_px(v0, 7);
        checks++;
        if (obs !== exp_pixel(v0, 7) || rend_colour_on !== C_HL) begin
            errors++; $display("FAIL select_band0 got %h exp %h", obs, exp_pixel(v0, 7));
        end
        drive_px(v1, 7);
        checks++;
        if (obs !== exp_pixel(v1, 7) || rend_colour_on !== C_ON) begin
            errors++; $display("FAIL select_band1 got %h exp %h", obs, exp_pixel(v1, 7));
        end
    endtask

    task automatic test_sequence();
        int v, h;
        for (int f = 0; f < 5; f++) begin
            if (f < 3) begin
                pulse_sel();
                do_fb();
            end else if (f == 3) begin
                // Button edge lands exactly on the frame-boundary cycle.
                sel_step = 1'b1;
                repeat (2) @(negedge clk);
                drive_px(SNAP_LINE, 0);
                m_pend = 1;
                model_fb();
                vga_v    = 11'd0;
                vga_h    = 11'd1;
                sel_step = 1'b0;
                @(negedge clk);
            end else begin
                do_fb();
            end
            for (int k = 0; k < 4; k++) begin
                v = PANEL_V + k * BAND_PITCH + $urandom_range(0, BAND_PITCH - 1);
                h = $urandom_range(0, 799);
                drive_px(v, h);
                checks++;
                if (obs !== exp_pixel(v, h)) begin
                    errors++; $display("FAIL seq f=%0d band=%0d got %h exp %h", f, k, obs, exp_pixel(v, h));
                end
            end
        end
    endtask

    task automatic test_frame_cnt();
        int ticks = 0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 256; i++) begin
            drive_px(SNAP_LINE, 0);
            model_fb();
            if (frame_tick === 1'b1) ticks++;
            drive_px(0, 1);
            if (frame_tick === 1'b1) ticks++;
            if (i == 254) begin
                checks++;
                if (frame_cnt !== 8'(m_cnt)) begin
                    errors++; $display("FAIL cnt_255 got %0d exp %0d", frame_cnt, m_cnt);
                end
            end
        end
        checks++;
        if (frame_cnt !== 8'(m_cnt)) begin
            errors++; $display("FAIL cnt_wrap got %0d exp %0d", frame_cnt, m_cnt);
        end
        checks++;
        if (ticks != 256) begin
            errors++; $display("FAIL tick_count got %0d exp 256", ticks);
        end
    endtask

    task automatic test_reset_mid();
        randomise_regs();
        do_fb();
        pulse_sel();
        vga_v = 11'(PANEL_V + 3);
        vga_h = 11'd9;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_OBS) begin
            errors++; $display("FAIL midreset_outputs got %h exp %h", obs, RESET_OBS);
        end
        checks++;
        if ({frame_tick, frame_cnt} !== 9'd0) begin
            errors++; $display("FAIL midreset_frame got %b/%0d exp 0/0", frame_tick, frame_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        randomise_regs();
        do_fb();
        drive_px(PANEL_V + 3, 9);
        checks++;
        if (obs !== exp_pixel(PANEL_V + 3, 9)) begin
            errors++; $display("FAIL midreset_snap got %h exp %h", obs, exp_pixel(PANEL_V + 3, 9));
        end
        checks++;
        if (frame_cnt !== 8'(m_cnt)) begin
            errors++; $display("FAIL midreset_cnt got %0d exp %0d", frame_cnt, m_cnt);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        hold     = 1'b0;
        sel_step = 1'b0;
        vga_v    = 11'd0;
        vga_h    = 11'd0;
        randomise_regs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_snapshot();
        test_bands();
        test_hold();
        test_select();
        test_sequence();
        test_frame_cnt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
